// File: rtl/naive_bus_arbiter2_if.sv
// Naive-bus port bundle: one read channel and one write channel.
// A channel transfers in the cycle where req and gnt are both high; read data follows one cycle later.
interface naive_bus_arbiter2_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              rd_req;
  logic              rd_gnt;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic              wr_req;
  logic              wr_gnt;
  logic [AW-1:0]     wr_addr;
  logic [DW/8-1:0]   wr_byte;
  logic [DW-1:0]     wr_data;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_byte, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_byte, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/naive_bus_arbiter2.sv
// Two-master naive-bus arbiter: m0 (ISP debugger) and m1 (CPU data) share one slave port.
// Round-robin per cycle, ownership held across slave stalls, read data steered one cycle after grant.
module naive_bus_arbiter2 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_lock,
  naive_bus_arbiter2_if.slave  m0,
  naive_bus_arbiter2_if.slave  m1,
  naive_bus_arbiter2_if.master s,
  output logic [2:0]           dbg_state
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    HOLD_NONE = 2'd0,
    HOLD_M0   = 2'd1,
    HOLD_M1   = 2'd2
  } hold_e;

  hold_e hold_q, hold_d;
  logic  last_grant_q, last_grant_d;
  logic  rd_owner_q, rd_owner_d;
  logic  rd_owner_valid_q, rd_owner_valid_d;

  logic          req0, req1;
  logic          sel;
  logic          sel_rd_req, sel_wr_req;
  logic          fwd_rd, fwd_wr, fwd_any;
  logic          rd_hit, wr_hit, hit_any;
  logic [AW-1:0] rd_addr_mux, wr_addr_mux;
  logic [BW-1:0] wr_byte_mux;
  logic [DW-1:0] wr_data_mux;

  assign req0 = m0.rd_req | m0.wr_req;
  assign req1 = m1.rd_req | m1.wr_req;

  // A held transfer outranks lock, so a stalled m1 access finishes before lock bites.
  always_comb begin
    sel = 1'b0;
    if (hold_q != HOLD_NONE) begin
      sel = (hold_q == HOLD_M1);
    end else if (m0_lock) begin
      sel = 1'b0;
    end else if (req0 && req1) begin
      sel = ~last_grant_q;
    end else if (req1) begin
      sel = 1'b1;
    end
  end

  assign sel_rd_req  = sel ? m1.rd_req  : m0.rd_req;
  assign sel_wr_req  = sel ? m1.wr_req  : m0.wr_req;
  assign rd_addr_mux = sel ? m1.rd_addr : m0.rd_addr;
  assign wr_addr_mux = sel ? m1.wr_addr : m0.wr_addr;
  assign wr_byte_mux = sel ? m1.wr_byte : m0.wr_byte;
  assign wr_data_mux = sel ? m1.wr_data : m0.wr_data;

  // Read wins over write inside the selected master; reset silences the slave side immediately.
  assign fwd_rd  = rst_n & sel_rd_req;
  assign fwd_wr  = rst_n & ~sel_rd_req & sel_wr_req;
  assign fwd_any = fwd_rd | fwd_wr;

  assign s.rd_req  = fwd_rd;
  assign s.rd_addr = rd_addr_mux;
  assign s.wr_req  = fwd_wr;
  assign s.wr_addr = wr_addr_mux;
  assign s.wr_byte = wr_byte_mux;
  assign s.wr_data = wr_data_mux;

  assign rd_hit  = fwd_rd & s.rd_gnt;
  assign wr_hit  = fwd_wr & s.wr_gnt;
  assign hit_any = rd_hit | wr_hit;

  assign m0.rd_gnt = rd_hit & ~sel;
  assign m1.rd_gnt = rd_hit &  sel;
  assign m0.wr_gnt = wr_hit & ~sel;
  assign m1.wr_gnt = wr_hit &  sel;

  assign m0.rd_data = (rd_owner_valid_q && !rd_owner_q) ? s.rd_data : '0;
  assign m1.rd_data = (rd_owner_valid_q &&  rd_owner_q) ? s.rd_data : '0;

  // Hold only while a forwarded request waits; a dropped request releases the hold.
  always_comb begin
    hold_d           = HOLD_NONE;
    last_grant_d     = last_grant_q;
    rd_owner_d       = rd_owner_q;
    rd_owner_valid_d = rd_hit;
    if (fwd_any && !hit_any) begin
      hold_d = sel ? HOLD_M1 : HOLD_M0;
    end
    if (hit_any) begin
      last_grant_d = sel;
    end
    if (rd_hit) begin
      rd_owner_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q           <= HOLD_NONE;
      last_grant_q     <= 1'b1;
      rd_owner_q       <= 1'b0;
      rd_owner_valid_q <= 1'b0;
    end else begin
      hold_q           <= hold_d;
      last_grant_q     <= last_grant_d;
      rd_owner_q       <= rd_owner_d;
      rd_owner_valid_q <= rd_owner_valid_d;
    end
  end

  assign dbg_state = {last_grant_q, hold_q};

endmodule

// File: doc/naive_bus_arbiter2.md
Name: naive_bus_arbiter2

Overview:
- Shares one naive-bus slave port between two masters: m0 = ISP UART debugger, m1 = CPU data port.
- Sits in soc_top between the masters and the bus router, so the ISP can read and write memory and peripherals while the core runs.
- Per-cycle round-robin arbitration; ownership is held across slave stalls; read data is steered one cycle after grant; m0 can lock out m1.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte-enable width is DW/8)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- mX_rd_req  input  1  read request, X in {0,1}
- mX_rd_gnt  output  1  read accepted this cycle
- mX_rd_addr  input  AW  read address
- mX_rd_data  output  DW  read data, valid the cycle after mX_rd_gnt
- mX_wr_req  input  1  write request
- mX_wr_gnt  output  1  write accepted this cycle
- mX_wr_addr  input  AW  write address
- mX_wr_byte  input  DW/8  byte enables
- mX_wr_data  input  DW  write data
- m0_lock  input  1  ISP exclusive-access request; blocks new m1 selection
- s_rd_req / s_rd_gnt / s_rd_addr / s_rd_data  out/in/out/in  1/1/AW/DW  slave read channel
- s_wr_req / s_wr_gnt / s_wr_addr / s_wr_byte / s_wr_data  out/in/out/out/out  1/1/AW/DW/8/DW  slave write channel

Behaviour:
- One clock domain. rst_n clears all registers asynchronously.
- Reset values:
  - last_grant = 1, so m0 wins the first tie.
  - pend_valid = 0, pend_owner = 0.
  - rd_owner_valid = 0.
  - All gnt outputs are 0 because they are combinational from s_*_gnt and selection; all mX_rd_data are 0.
- Master request: req_X = mX_rd_req | mX_wr_req.
  - Within one master, read has priority over write.
  - Only one channel (rd or wr) of the selected master is forwarded per cycle; the other slave req is 0.
- Selection, combinational:
  - If pend_valid: sel = pend_owner.
  - Else if m0_lock: sel = 0 (m1 is never selected).
  - Else if both request: sel = ~last_grant.
  - Else: sel = the single requester. If none, no slave req.
- Forwarding:
  - The selected master's chosen channel address, byte and data drive s_*.
  - s_*_req = that master's channel req.
  - mX_*_gnt = (sel==X) & channel chosen & s_*_gnt. The non-selected master always sees gnt = 0.
- Stall hold:
  - If a selected request is not granted: pend_valid <= 1 and pend_owner <= sel.
  - Cleared on the cycle the grant occurs.
  - If the owning master drops its request while pending, pend_valid clears the next cycle (no grant is issued).
- Lock during a pending m1 transfer: the m1 transfer still completes first, and lock takes effect the following cycle.
- On any grant: last_grant <= sel.
- Read return:
  - On s_rd_gnt: rd_owner <= sel and rd_owner_valid <= 1; otherwise rd_owner_valid <= 0.
  - mX_rd_data = (rd_owner_valid & rd_owner==X) ? s_rd_data : 0.
  - Back-to-back reads by alternating masters each route correctly.
- Latency:
  - Zero added cycles on request and grant (combinational path).
  - Read data returns at grant+1, same as a direct connection.
- Reset mid-operation: pending state and return routing are dropped, and mX_rd_data goes to 0 immediately.

Test Plan:
- Only m1 reads addr 0x0000_0010 with the slave always granting and returning 0xDEADBEEF next cycle -> m1_rd_gnt=1 in the same cycle; m1_rd_data=0xDEADBEEF at +1; m0_rd_data=0.
- m0 writes 0x2000_0000 and m1 writes 0x0000_0100 every cycle with the slave always granting -> grants alternate m0, m1, m0, m1 starting with m0 after reset.
- m1 read selected while s_rd_gnt is held 0 for 3 cycles, m0 raising a request in cycle 1 -> s_rd_addr stays at the m1 address for 4 cycles; m1 is granted in cycle 4 and m0 in cycle 5.
- m0_lock=1 with both masters requesting for 5 cycles -> m0 granted 5 times and m1_*_gnt=0 throughout; after lock drops, m1 is granted next.
- Alternating reads m0 (data 0x11111111) then m1 (data 0x22222222) -> m0_rd_data=0x11111111 at cycle 1 and m1_rd_data=0x22222222 at cycle 2, with the other master's data 0 in each cycle.
- Assert rst_n=0 asynchronously during a pending m1 stall -> all gnts and rd_data go to 0 immediately; after release, a tie is granted to m0.
